// File: rtl/amo_pkg.sv
// Shared definitions for the RV32A atomic unit: funct5 encodings, FSM states
// and a helper that says whether an opcode writes memory after reading it.
package amo_pkg;

    localparam int XLEN = 32;

    // RV32A funct5 encodings
    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } amo_state_t;

    // True for read-modify-write AMOs. LR and unknown opcodes only read.
    function automatic logic amo_writes(input logic [4:0] op);
        logic w;
        case (op)
            AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: w = 1'b1;
            default:                              w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/atomic_unit_if.sv
// Memory port of the atomic unit.
// Handshake: the unit raises mem_req with mem_we/mem_addr/mem_wdata and holds
// all of them stable until a clock edge where mem_ack is high; the transfer
// completes on that edge. mem_rdata is only meaningful while mem_ack is high.
interface atomic_unit_if;
    import amo_pkg::*;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/amo_alu.sv
// Combinational AMO datapath: new memory word from the old word and rs2.
module amo_alu
    import amo_pkg::*;
(
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] new_word
);

    // Select the read-modify-write result; non-writing opcodes keep the old word
    always_comb begin
        new_word = old_word;
        case (op)
            AMO_SWAP: new_word = rs2;
            AMO_ADD:  new_word = old_word + rs2;
            AMO_XOR:  new_word = old_word ^ rs2;
            AMO_AND:  new_word = old_word & rs2;
            AMO_OR:   new_word = old_word | rs2;
            AMO_MIN:  new_word = ($signed(old_word) < $signed(rs2)) ? old_word : rs2;
            AMO_MAX:  new_word = ($signed(old_word) > $signed(rs2)) ? old_word : rs2;
            AMO_MINU: new_word = (old_word < rs2) ? old_word : rs2;
            AMO_MAXU: new_word = (old_word > rs2) ? old_word : rs2;
            default:  new_word = old_word;
        endcase
    end

endmodule

// File: rtl/atomic_unit.sv
// RV32A atomic unit in the MEM stage. Sequences LR/SC/AMO accesses over a
// single memory port, keeps the LR reservation and stalls the pipeline until
// the operation reaches its one-cycle DONE state.
module atomic_unit
    import amo_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            is_atomic_mem,
    input  logic [4:0]      amo_op,
    input  logic [XLEN-1:0] addr_mem,
    input  logic [XLEN-1:0] rs2_data_mem,
    input  logic            store_snoop_valid,
    input  logic [XLEN-1:0] store_snoop_addr,
    atomic_unit_if.master   mem,
    output logic            atomic_unit_stall,
    output logic [XLEN-1:0] amo_result,
    output logic            amo_misaligned,
    output amo_state_t      fsm_state
);

    amo_state_t      state;
    logic            resv_valid;
    logic [29:0]     resv_addr;
    logic [XLEN-1:0] alu_out;

    logic misaligned;
    logic is_lr;
    logic is_sc;
    logic sc_ok;
    logic snoop_hit;
    logic snoop_unused;

    assign misaligned = (addr_mem[1:0] != 2'b00);
    assign is_lr      = (amo_op == AMO_LR);
    assign is_sc      = (amo_op == AMO_SC);
    assign sc_ok      = resv_valid && (resv_addr == addr_mem[31:2]);
    // Reservation granularity is a word, so the byte offset of the store is ignored
    assign snoop_hit    = store_snoop_valid && (store_snoop_addr[31:2] == resv_addr);
    assign snoop_unused = ^store_snoop_addr[1:0];

    assign atomic_unit_stall = is_atomic_mem && (state != ST_DONE);
    assign fsm_state         = state;

    amo_alu u_alu (
        .op       (amo_op),
        .old_word (mem.mem_rdata),
        .rs2      (rs2_data_mem),
        .new_word (alu_out)
    );

    // Main sequencer: IDLE -> READ -> WRITE -> DONE with registered bus outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            amo_result     <= '0;
            amo_misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_atomic_mem) begin
                        if (misaligned) begin
                            // Trap path: no bus traffic, report in DONE
                            state          <= ST_DONE;
                            amo_result     <= '0;
                            amo_misaligned <= 1'b1;
                        end else if (is_sc) begin
                            if (sc_ok) begin
                                state         <= ST_WRITE;
                                mem.mem_req   <= 1'b1;
                                mem.mem_we    <= 1'b1;
                                mem.mem_addr  <= addr_mem;
                                mem.mem_wdata <= rs2_data_mem;
                                amo_result    <= '0;
                            end else begin
                                state      <= ST_DONE;
                                amo_result <= 32'd1;
                            end
                        end else begin
                            state        <= ST_READ;
                            mem.mem_req  <= 1'b1;
                            mem.mem_we   <= 1'b0;
                            mem.mem_addr <= addr_mem;
                        end
                    end
                end
                ST_READ: begin
                    if (mem.mem_ack) begin
                        amo_result <= mem.mem_rdata;
                        if (amo_writes(amo_op)) begin
                            // Keep mem_req high straight into the write beat
                            state         <= ST_WRITE;
                            mem.mem_we    <= 1'b1;
                            mem.mem_wdata <= alu_out;
                        end else begin
                            state       <= ST_DONE;
                            mem.mem_req <= 1'b0;
                            mem.mem_we  <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem.mem_ack) begin
                        state       <= ST_DONE;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state          <= ST_IDLE;
                    amo_misaligned <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // LR reservation: snoop and SC clear it, a completing LR sets it and wins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resv_valid <= 1'b0;
            resv_addr  <= '0;
        end else begin
            if (snoop_hit) begin
                resv_valid <= 1'b0;
            end
            if ((state == ST_IDLE) && is_atomic_mem && is_sc) begin
                resv_valid <= 1'b0;
            end
            if ((state == ST_READ) && mem.mem_ack && is_lr) begin
                resv_valid <= 1'b1;
                resv_addr  <= addr_mem[31:2];
            end
        end
    end

endmodule

// File: tb/tb_atomic_unit.sv
// Self-checking bench for atomic_unit: behavioural memory with programmable
// ack delay, scoreboard of expected writes, and directed plus random AMOs.
module tb_atomic_unit;
    import amo_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        is_atomic_mem;
    logic [4:0]  amo_op;
    logic [31:0] addr_mem;
    logic [31:0] rs2_data_mem;
    logic        store_snoop_valid;
    logic [31:0] store_snoop_addr;
    logic        atomic_unit_stall;
    logic [31:0] amo_result;
    logic        amo_misaligned;
    amo_state_t  fsm_state;

    atomic_unit_if mem_bus ();

    atomic_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .is_atomic_mem     (is_atomic_mem),
        .amo_op            (amo_op),
        .addr_mem          (addr_mem),
        .rs2_data_mem      (rs2_data_mem),
        .store_snoop_valid (store_snoop_valid),
        .store_snoop_addr  (store_snoop_addr),
        .mem               (mem_bus.master),
        .atomic_unit_stall (atomic_unit_stall),
        .amo_result        (amo_result),
        .amo_misaligned    (amo_misaligned),
        .fsm_state         (fsm_state)
    );

    // Clock and scoreboard state
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] res_q[$];
    logic [31:0] mem_arr [0:255];
    int          ack_wait = 0;
    int          wait_cnt = 0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_wdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural memory: ack after ack_wait cycles of held request
    assign mem_bus.mem_ack   = mem_bus.mem_req && (wait_cnt >= ack_wait);
    assign mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (reset_n && mem_bus.mem_req && mem_bus.mem_we && mem_bus.mem_ack)
            mem_arr[mem_bus.mem_addr[9:2]] = mem_bus.mem_wdata;
        wait_cnt <= (mem_bus.mem_req && !mem_bus.mem_ack) ? wait_cnt + 1 : 0;
    end

    // Bus monitor: request stability and write scoreboard
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset_n && mem_bus.mem_req) begin
            check("req_addr", mem_bus.mem_addr, cur_addr);
            if (mem_bus.mem_we) check("req_wdata", mem_bus.mem_wdata, cur_wdata);
            if (mem_bus.mem_we && mem_bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", mem_bus.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", mem_bus.mem_addr, e[63:32]);
                    check("wr_data", mem_bus.mem_wdata, e[31:0]);
                end
            end
        end
    end

    // Reference AMO arithmetic
    function automatic logic [31:0] ref_amo(input logic [4:0] op, input logic [31:0] m, input logic [31:0] r);
        case (op)
            5'b00001: return r;
            5'b00000: return m + r;
            5'b00100: return m ^ r;
            5'b01100: return m & r;
            5'b01000: return m | r;
            5'b10000: return ($signed(m) < $signed(r)) ? m : r;
            5'b10100: return ($signed(m) > $signed(r)) ? m : r;
            5'b11000: return (m < r) ? m : r;
            5'b11100: return (m > r) ? m : r;
            default:  return m;
        endcase
    endfunction

    // Driver: run one atomic op and check stall length, result and misalignment
    task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                         input int w, input int exp_stall, input logic [31:0] exp_res,
                         input bit exp_wr, input logic [31:0] exp_wdata, input bit exp_mis);
        int stalls;
        int reqs;
        bit done;
        ack_wait  = w;
        cur_addr  = addr;
        cur_wdata = exp_wdata;
        if (exp_wr) exp_q.push_back({addr, exp_wdata});
        res_q.push_back(exp_res);
        @(posedge clk); #1;
        is_atomic_mem = 1'b1;
        amo_op        = op;
        addr_mem      = addr;
        rs2_data_mem  = rs2;
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (atomic_unit_stall) begin
                stalls++;
                if (mem_bus.mem_req) reqs++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
            void'(res_q.pop_front());
        end else begin
            check("stall_cycles", 32'(stalls), 32'(exp_stall));
            check("amo_result", amo_result, res_q.pop_front());
            check("misaligned", 32'(amo_misaligned), 32'(exp_mis));
            if (exp_mis) check("misaligned_no_req", 32'(reqs), 32'd0);
            check("write_pending", 32'(exp_q.size()), 32'd0);
        end
        @(posedge clk); #1;
        is_atomic_mem = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] addr);
        @(posedge clk); #1;
        store_snoop_valid = 1'b1;
        store_snoop_addr  = addr;
        @(posedge clk); #1;
        store_snoop_valid = 1'b0;
    endtask

    logic [4:0]  op_tab [0:9];
    int          idx;
    int          k;
    int          w;
    logic [4:0]  op;
    logic [31:0] old_w;
    logic [31:0] rs2;
    logic [31:0] addr;
    bit          seen;
    int          rd_cycles;
    int          st_cycles;

    // Stimulus sequence
    initial begin
        op_tab = '{5'b00000, 5'b00001, 5'b00100, 5'b01100, 5'b01000,
                   5'b10000, 5'b10100, 5'b11000, 5'b11100, 5'b00010};
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'(i) * 32'h0101_0101;
        reset_n = 1'b0;
        is_atomic_mem = 1'b0;
        amo_op = '0;
        addr_mem = '0;
        rs2_data_mem = '0;
        store_snoop_valid = 1'b0;
        store_snoop_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_we", 32'(mem_bus.mem_we), 32'd0);
        check("rst_addr", mem_bus.mem_addr, 32'd0);
        check("rst_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_stall", 32'(atomic_unit_stall), 32'd0);
        check("rst_result", amo_result, 32'd0);
        check("rst_misaligned", 32'(amo_misaligned), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        reset_n = 1'b1;

        // AMOADD.W: 5 + 3
        mem_arr[32'h100 >> 2] = 32'd5;
        do_op(5'b00000, 32'h100, 32'd3, 0, 3, 32'd5, 1'b1, 32'd8, 1'b0);

        // LR / SC success, then SC without reservation fails
        mem_arr[32'h200 >> 2] = 32'h77;
        do_op(5'b00010, 32'h200, 32'd0, 0, 2, 32'h77, 1'b0, 32'd0, 1'b0);
        do_op(5'b00011, 32'h200, 32'hA5, 0, 2, 32'd0, 1'b1, 32'hA5, 1'b0);
        check("sc_mem", mem_arr[32'h200 >> 2], 32'hA5);
        do_op(5'b00011, 32'h200, 32'h5A, 0, 1, 32'd1, 1'b0, 32'd0, 1'b0);

        // Snooped store kills the reservation
        do_op(5'b00010, 32'h200, 32'd0, 0, 2, 32'hA5, 1'b0, 32'd0, 1'b0);
        snoop(32'h200);
        do_op(5'b00011, 32'h200, 32'h33, 0, 1, 32'd1, 1'b0, 32'd0, 1'b0);
        check("snoop_mem", mem_arr[32'h200 >> 2], 32'hA5);

        // Store to a different word leaves it intact
        do_op(5'b00010, 32'h200, 32'd0, 0, 2, 32'hA5, 1'b0, 32'd0, 1'b0);
        snoop(32'h204);
        do_op(5'b00011, 32'h200, 32'h44, 1, 3, 32'd0, 1'b1, 32'h44, 1'b0);

        // Signed vs unsigned minimum
        mem_arr[32'h110 >> 2] = 32'hFFFF_FFFF;
        do_op(5'b10000, 32'h110, 32'd1, 0, 3, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);
        do_op(5'b11000, 32'h110, 32'd1, 0, 3, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b0);

        // Misaligned AMOSWAP
        do_op(5'b00001, 32'h102, 32'hDEAD, 0, 1, 32'd0, 1'b0, 32'd0, 1'b1);

        // Random AMOs, including an unknown opcode, with random ack delay
        for (int i = 0; i < 16; i++) begin
            idx   = $urandom_range(0, 255);
            k     = $urandom_range(0, 9);
            w     = $urandom_range(0, 2);
            op    = (k == 9) ? 5'b00101 : op_tab[k];
            addr  = 32'(idx) << 2;
            old_w = mem_arr[idx];
            rs2   = $urandom;
            if (k == 9)
                do_op(op, addr, rs2, w, 2 + w, old_w, 1'b0, 32'd0, 1'b0);
            else
                do_op(op, addr, rs2, w, 3 + 2 * w, old_w, 1'b1, ref_amo(op, old_w, rs2), 1'b0);
        end

        // Reset during the write beat of a slow AMOOR
        do_op(5'b00010, 32'h200, 32'd0, 0, 2, mem_arr[32'h200 >> 2], 1'b0, 32'd0, 1'b0);
        mem_arr[32'h300 >> 2] = 32'h0F0;
        ack_wait  = 4;
        cur_addr  = 32'h300;
        cur_wdata = 32'hFF0;
        @(posedge clk); #1;
        is_atomic_mem = 1'b1;
        amo_op        = 5'b01000;
        addr_mem      = 32'h300;
        rs2_data_mem  = 32'hF00;
        seen = 1'b0;
        rd_cycles = 0;
        st_cycles = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (atomic_unit_stall) st_cycles++;
            if (mem_bus.mem_req && mem_bus.mem_we) begin
                seen = 1'b1;
            end else begin
                if (mem_bus.mem_req) rd_cycles++;
                @(posedge clk); #1;
            end
        end
        check("slow_write_reached", 32'(seen), 32'd1);
        check("slow_read_cycles", 32'(rd_cycles), 32'd5);
        check("slow_stall_cycles", 32'(st_cycles), 32'd7);
        @(posedge clk); #1;
        reset_n = 1'b0;
        is_atomic_mem = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
        check("mid_rst_req", 32'(mem_bus.mem_req), 32'd0);
        check("mid_rst_we", 32'(mem_bus.mem_we), 32'd0);
        check("mid_rst_addr", mem_bus.mem_addr, 32'd0);
        check("mid_rst_result", amo_result, 32'd0);
        check("mid_rst_stall", 32'(atomic_unit_stall), 32'd0);
        check("mid_rst_mem", mem_arr[32'h300 >> 2], 32'h0F0);
        @(posedge clk); #1;
        reset_n  = 1'b1;
        ack_wait = 0;

        // Reservation was dropped by reset
        do_op(5'b00011, 32'h200, 32'h99, 0, 1, 32'd1, 1'b0, 32'd0, 1'b0);

        check("final_exp_q", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
